// File: rtl/writeback_select_pipe.sv
// Write-back source selector with a registered output stage.
// Chooses one of NUM_SRC packed sources or late memory data, waits for memory
// loads with a bounded timeout, and flags illegal selects and memory timeouts.
module writeback_select_pipe #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned NUM_SRC     = 4,
  parameter int unsigned SEL_W       = 4,
  parameter int unsigned MEM_SEL     = 15,
  parameter int unsigned RADDR_W     = 5,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic [NUM_SRC*WIDTH-1:0] in_data,
  input  logic [RADDR_W-1:0]       in_rd,
  input  logic                     in_we,
  input  logic                     mem_valid,
  input  logic [WIDTH-1:0]         mem_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [RADDR_W-1:0]       out_rd,
  output logic                     out_we,
  output logic                     sel_error,
  output logic                     timeout_error
);

  typedef enum logic [1:0] {StEmpty, StWaitMem, StFull} state_e;

  state_e             state_q;
  logic [7:0]         cnt_q;
  logic               pend_we_q;
  logic [WIDTH-1:0]   src_data;
  logic               src_hit;
  logic               mem_hit;
  logic               accept;
  logic               wr_en;

  // Ready depends only on state, out_ready and flush so upstream sees no loop.
  always_comb begin
    in_ready = 1'b0;
    if (!flush) begin
      unique case (state_q)
        StEmpty: in_ready = 1'b1;
        StFull:  in_ready = out_ready;
        default: in_ready = 1'b0;
      endcase
    end
  end

  // Decode the select into a source slice; loop form avoids an out-of-range index.
  always_comb begin
    src_data = '0;
    src_hit  = 1'b0;
    for (int k = 0; k < int'(NUM_SRC); k++) begin
      if (in_sel == SEL_W'(k)) begin
        src_data = in_data[k*WIDTH +: WIDTH];
        src_hit  = 1'b1;
      end
    end
  end

  assign mem_hit = (in_sel == SEL_W'(MEM_SEL));
  assign accept  = in_valid && in_ready && !flush;
  assign wr_en   = in_we && (in_rd != '0);

  // Control FSM and registered result stage.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StEmpty;
      cnt_q         <= '0;
      pend_we_q     <= 1'b0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_rd        <= '0;
      out_we        <= 1'b0;
      sel_error     <= 1'b0;
      timeout_error <= 1'b0;
    end else if (flush) begin
      state_q   <= StEmpty;
      out_valid <= 1'b0;
      cnt_q     <= '0;
    end else if (accept) begin
      // Only reachable from EMPTY or FULL, which also covers back-to-back.
      out_rd <= in_rd;
      if (src_hit) begin
        out_data  <= src_data;
        out_we    <= wr_en;
        out_valid <= 1'b1;
        state_q   <= StFull;
      end else if (mem_hit && mem_valid) begin
        out_data  <= mem_data;
        out_we    <= wr_en;
        out_valid <= 1'b1;
        state_q   <= StFull;
      end else if (mem_hit) begin
        pend_we_q <= wr_en;
        out_we    <= 1'b0;
        out_valid <= 1'b0;
        cnt_q     <= '0;
        state_q   <= StWaitMem;
      end else begin
        out_data  <= '0;
        out_we    <= 1'b0;
        out_valid <= 1'b1;
        sel_error <= 1'b1;
        state_q   <= StFull;
      end
    end else begin
      unique case (state_q)
        StFull: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= StEmpty;
          end
        end
        StWaitMem: begin
          // Data arriving on the expiry cycle still wins.
          if (mem_valid) begin
            out_data  <= mem_data;
            out_we    <= pend_we_q;
            out_valid <= 1'b1;
            state_q   <= StFull;
          end else if (cnt_q == 8'(MEM_TIMEOUT - 1)) begin
            out_data      <= '0;
            out_we        <= 1'b0;
            out_valid     <= 1'b1;
            timeout_error <= 1'b1;
            cnt_q         <= '0;
            state_q       <= StFull;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_select_pipe.sv
// Directed bench for writeback_select_pipe with hand-computed expectations.
module tb_writeback_select_pipe;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   in_sel;
  logic [127:0] in_data;
  logic [4:0]   in_rd;
  logic         in_we;
  logic         mem_valid;
  logic [31:0]  mem_data;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic [4:0]   out_rd;
  logic         out_we;
  logic         sel_error;
  logic         timeout_error;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] src [4];

  writeback_select_pipe dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sel        (in_sel),
    .in_data       (in_data),
    .in_rd         (in_rd),
    .in_we         (in_we),
    .mem_valid     (mem_valid),
    .mem_data      (mem_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_rd        (out_rd),
    .out_we        (out_we),
    .sel_error     (sel_error),
    .timeout_error (timeout_error)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one cycle; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    src[0] = 32'h1111_1111;
    src[1] = 32'h2222_2222;
    src[2] = 32'h0000_ABCD;
    src[3] = 32'h3333_3333;
    in_data   = {src[3], src[2], src[1], src[0]};
    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_sel    = '0;
    in_rd     = '0;
    in_we     = 1'b0;
    mem_valid = 1'b0;
    mem_data  = '0;
    out_ready = 1'b0;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_errors", {30'd0, sel_error, timeout_error}, 32'd0);
    reset_n = 1'b1;
    step();
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Basic select of source 2.
    in_valid = 1'b1; in_sel = 4'd2; in_rd = 5'd7; in_we = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("sel2_valid", 32'(out_valid), 32'd1);
    check("sel2_data", out_data, 32'h0000_ABCD);
    check("sel2_rd", 32'(out_rd), 32'd7);
    check("sel2_we", 32'(out_we), 32'd1);
    step();
    check("sel2_drain", 32'(out_valid), 32'd0);

    // Memory load with data arriving after four idle cycles.
    in_valid = 1'b1; in_sel = 4'd15; in_rd = 5'd3; in_we = 1'b1;
    step();
    in_valid = 1'b0;
    check("mem_wait_ready", 32'(in_ready), 32'd0);
    check("mem_wait_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 3; i++) step();
    check("mem_wait_ready2", 32'(in_ready), 32'd0);
    mem_valid = 1'b1; mem_data = 32'hDEAD_BEEF;
    step();
    mem_valid = 1'b0;
    check("mem_valid", 32'(out_valid), 32'd1);
    check("mem_data", out_data, 32'hDEAD_BEEF);
    check("mem_we", 32'(out_we), 32'd1);
    check("mem_rd", 32'(out_rd), 32'd3);
    step();

    // Memory timeout: expiry exactly 15 edges after accept.
    in_valid = 1'b1; in_sel = 4'd15; in_rd = 5'd4; in_we = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 14; i++) step();
    check("to_early_valid", 32'(out_valid), 32'd0);
    check("to_early_flag", 32'(timeout_error), 32'd0);
    step();
    check("to_valid", 32'(out_valid), 32'd1);
    check("to_data", out_data, 32'd0);
    check("to_we", 32'(out_we), 32'd0);
    check("to_flag", 32'(timeout_error), 32'd1);
    step();
    step();
    check("to_sticky", 32'(timeout_error), 32'd1);

    // Back-to-back sources 0..3, then stall.
    in_valid = 1'b1; in_rd = 5'd9; in_we = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_sel = 4'(i);
      step();
      check($sformatf("b2b_valid%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("b2b_data%0d", i), out_data, src[i]);
    end
    in_sel = 4'd0; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("stall_ready%0d", i), 32'(in_ready), 32'd0);
      step();
      check($sformatf("stall_data%0d", i), out_data, src[3]);
      check($sformatf("stall_valid%0d", i), 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    check("stall_drain", 32'(out_valid), 32'd0);

    // Illegal select.
    in_valid = 1'b1; in_sel = 4'd5; in_rd = 5'd6; in_we = 1'b1;
    step();
    in_valid = 1'b0;
    check("badsel_data", out_data, 32'd0);
    check("badsel_we", 32'(out_we), 32'd0);
    check("badsel_flag", 32'(sel_error), 32'd1);
    step();

    // Register 0 is never written.
    in_valid = 1'b1; in_sel = 4'd1; in_rd = 5'd0; in_we = 1'b1;
    step();
    in_valid = 1'b0;
    check("rd0_data", out_data, src[1]);
    check("rd0_we", 32'(out_we), 32'd0);
    step();

    // Flush during memory wait; late mem_valid ignored.
    in_valid = 1'b1; in_sel = 4'd15; in_rd = 5'd8; in_we = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b1;
    #1;
    check("flush_ready", 32'(in_ready), 32'd0);
    step();
    flush = 1'b0; mem_valid = 1'b1; mem_data = 32'hCAFE_F00D;
    step();
    mem_valid = 1'b0;
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_empty", 32'(in_ready), 32'd1);
    check("flush_keep_err", {30'd0, sel_error, timeout_error}, 32'd3);

    // Asynchronous reset while FULL.
    in_valid = 1'b1; in_sel = 4'd3; in_rd = 5'd2; in_we = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_data", out_data, 32'd0);
    check("arst_rd_we", {26'd0, out_rd, out_we}, 32'd0);
    check("arst_errors", {30'd0, sel_error, timeout_error}, 32'd0);
    #5;
    reset_n = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/writeback_select_pipe.md
# writeback_select_pipe

Parametrised write-back source selector with a registered output stage for the CatCORE datapath. Picks one of `NUM_SRC` candidate results (ALU, immediate, extended switches, …) or late-arriving memory data. Registers the chosen value with its destination register address. Presents the result to the register-file write port under a valid/ready handshake. Adds three things a plain combinational select lacks: a wait state for memory loads, a timeout, and error flags.

## Interface

Parameters:
- `WIDTH`, 32, data width of every source and of the output.
- `NUM_SRC`, 4, number of packed combinational sources (2..16; need not be a power of two).
- `SEL_W`, 4, select width; must satisfy 2^SEL_W ≥ NUM_SRC + 1.
- `MEM_SEL`, 15, select code meaning "take `mem_data`"; must be ≥ NUM_SRC.
- `RADDR_W`, 5, destination register address width.
- `MEM_TIMEOUT`, 15, cycles spent in WAIT_MEM before abort (1..255).

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous pipeline flush.
- `in_valid`  in  1  upstream request valid.
- `in_ready`  out  1  block can accept a request this cycle.
- `in_sel`  in  SEL_W  source select.
- `in_data`  in  NUM_SRC*WIDTH  packed sources; source k at bits [k*WIDTH +: WIDTH].
- `in_rd`  in  RADDR_W  destination register.
- `in_we`  in  1  request writes the register file.
- `mem_valid`  in  1  memory read data valid.
- `mem_data`  in  WIDTH  memory read data.
- `out_valid`  out  1  registered result valid.
- `out_ready`  in  1  register-file port accepts the result.
- `out_data`  out  WIDTH  selected value.
- `out_rd`  out  RADDR_W  destination register.
- `out_we`  out  1  write enable qualified by validity checks.
- `sel_error`  out  1  sticky: an illegal select was accepted.
- `timeout_error`  out  1  sticky: a memory wait timed out.

## Operation

- FSM states: EMPTY, WAIT_MEM, FULL.
- Accept condition: `in_valid && in_ready && !flush`.
- `in_ready` is 1 in EMPTY, `out_ready` in FULL, and 0 in WAIT_MEM or while `flush` is 1.
- On accept:
  - `out_rd` takes `in_rd`.
  - If `in_sel < NUM_SRC`: `out_data` takes slice `in_sel`, `out_we` takes `in_we && (in_rd != 0)`. Next state FULL.
  - If `in_sel == MEM_SEL` and `mem_valid` is 1 the same cycle: capture `mem_data`, `out_we` takes `in_we && (in_rd != 0)`. Next state FULL.
  - If `in_sel == MEM_SEL` and `mem_valid` is 0: hold `in_rd`/`in_we`, clear the timeout counter. Next state WAIT_MEM.
  - Any other select: `out_data` = 0, `out_we` = 0, `sel_error` set. Next state FULL.
- WAIT_MEM:
  - When `mem_valid` is 1: capture `mem_data`, apply the same `out_we` rule, go to FULL.
  - Otherwise the counter increments.
  - When the counter reaches MEM_TIMEOUT: `out_data` = 0, `out_we` = 0, `timeout_error` set, go to FULL.
  - `mem_valid` takes priority over expiry in the same cycle.
- FULL:
  - `out_valid` is 1.
  - `out_ready` with no accept: go to EMPTY.
  - `out_ready` with a simultaneous accept: next state is chosen by the accept rules above (back-to-back).
  - No `out_ready`: hold all outputs stable.
- `mem_valid` in EMPTY or FULL without an accepting MEM_SEL request is ignored.
- `flush` (any state): next state EMPTY, `out_valid` 0, counter 0. Error flags are kept; nothing is accepted that cycle.
- Register 0 is never written: `out_we` is 0 whenever `out_rd == 0`.

## Timing

- Reset (`reset_n` low, asynchronous):
  - State EMPTY; counter 0.
  - `out_valid`, `out_data`, `out_rd`, `out_we`, `sel_error`, `timeout_error` all 0.
  - `in_ready` reads 1 once reset is released.
- Reset asserted mid-WAIT_MEM or mid-FULL discards the pending result immediately.
- Latency: accept at edge N gives `out_valid` after edge N (visible in cycle N+1). Memory: `mem_valid` at edge M gives `out_valid` in cycle M+1.
- Throughput: one result per cycle while `out_ready` is held high and sources are non-memory or `mem_valid` arrives with the request.
- Timeout: accept at edge N with no `mem_valid` gives FULL with `timeout_error` set after edge N+MEM_TIMEOUT.
- `in_ready` is combinational from state, `out_ready` and `flush`. All other outputs are registered.

## Test plan

- Reset, then sel=2 with source2=0x0000_ABCD, rd=7, we=1, out_ready=1 → cycle+1: out_valid=1, out_data=0x0000_ABCD, out_rd=7, out_we=1; then EMPTY.
- sel=MEM_SEL, rd=3, mem_valid low 4 cycles then high with mem_data=0xDEAD_BEEF → in_ready=0 during wait; out_data=0xDEAD_BEEF, out_we=1 one cycle after mem_valid.
- sel=MEM_SEL, mem_valid never asserted, MEM_TIMEOUT=15 → 15 cycles later out_valid=1, out_data=0, out_we=0, timeout_error=1 and stays 1 until reset_n low.
- Back-to-back requests sel=0,1,2,3 with out_ready=1 → four consecutive out_valid cycles with matching data; then out_ready=0 for 3 cycles → outputs held, in_ready=0.
- sel=5 (NUM_SRC=4) → out_data=0, out_we=0, sel_error=1. Separately, rd=0 with we=1 → out_we=0.
- In WAIT_MEM assert flush, then mem_valid → out_valid stays 0 and state is EMPTY. Also assert reset_n low while FULL → all outputs 0 asynchronously.
